// File: rtl/apb_arbiter_master.sv
// Two-requester APB master: round-robin arbitration, IDLE/SETUP/ACCESS sequencing,
// address-bit slave decode and a PREADY timeout that aborts a stuck transfer.
`timescale 1ns/1ps
module apb_arbiter_master #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_BIT    = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_SIZE-1:0]  addr0,
    input  logic [ADDR_SIZE-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  write0,
    input  logic                  write1,
    output logic                  done0,
    output logic                  done1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_SIZE-1:0]  PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL1,
    output logic                  PSEL2,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA1,
    input  logic [DATA_WIDTH-1:0] PRDATA2,
    input  logic                  PREADY1,
    input  logic                  PREADY2
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_last_grant, w_last_grant_nxt;
    logic                  r_port, w_port_nxt;

    logic [ADDR_SIZE-1:0]  w_paddr_nxt;
    logic [DATA_WIDTH-1:0] w_pwdata_nxt;
    logic                  w_pwrite_nxt, w_psel1_nxt, w_psel2_nxt, w_penable_nxt;
    logic                  w_done0_nxt, w_done1_nxt, w_err0_nxt, w_err1_nxt;
    logic [DATA_WIDTH-1:0] w_rdata0_nxt, w_rdata1_nxt;

    logic                  w_req_any, w_grant;
    logic [ADDR_SIZE-1:0]  w_req_addr;
    logic                  w_sel2, w_ready, w_timeout;
    logic [DATA_WIDTH-1:0] w_prdata;

    // When both request, the port that did not win last time goes next.
    assign w_req_any  = req0 | req1;
    assign w_grant    = (req0 & req1) ? ~r_last_grant : req1;
    assign w_req_addr = w_grant ? addr1 : addr0;

    // Only the selected slave's handshake is looked at.
    assign w_sel2    = PADDR[SEL_BIT];
    assign w_ready   = w_sel2 ? PREADY2 : PREADY1;
    assign w_prdata  = w_sel2 ? PRDATA2 : PRDATA1;
    assign w_timeout = !w_ready && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
            PWRITE       <= 1'b0;
            PSEL1        <= 1'b0;
            PSEL2        <= 1'b0;
            PENABLE      <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_port       <= w_port_nxt;
            PADDR        <= w_paddr_nxt;
            PWDATA       <= w_pwdata_nxt;
            PWRITE       <= w_pwrite_nxt;
            PSEL1        <= w_psel1_nxt;
            PSEL2        <= w_psel2_nxt;
            PENABLE      <= w_penable_nxt;
            done0        <= w_done0_nxt;
            done1        <= w_done1_nxt;
            err0         <= w_err0_nxt;
            err1         <= w_err1_nxt;
            rdata0       <= w_rdata0_nxt;
            rdata1       <= w_rdata1_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_req_any) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_ready || w_timeout) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of every registered output, so nothing toggles combinationally.
    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_last_grant_nxt = r_last_grant;
        w_port_nxt       = r_port;
        w_paddr_nxt      = PADDR;
        w_pwdata_nxt     = PWDATA;
        w_pwrite_nxt     = PWRITE;
        w_psel1_nxt      = PSEL1;
        w_psel2_nxt      = PSEL2;
        w_penable_nxt    = PENABLE;
        w_done0_nxt      = 1'b0;
        w_done1_nxt      = 1'b0;
        w_err0_nxt       = 1'b0;
        w_err1_nxt       = 1'b0;
        w_rdata0_nxt     = rdata0;
        w_rdata1_nxt     = rdata1;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_port_nxt       = w_grant;
                    w_last_grant_nxt = w_grant;
                    w_paddr_nxt      = w_req_addr;
                    w_pwdata_nxt     = w_grant ? wdata1 : wdata0;
                    w_pwrite_nxt     = w_grant ? write1 : write0;
                    w_psel1_nxt      = ~w_req_addr[SEL_BIT];
                    w_psel2_nxt      = w_req_addr[SEL_BIT];
                    w_penable_nxt    = 1'b0;
                end
            end
            S_SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            S_ACCESS: begin
                if (w_ready || w_timeout) begin
                    w_done0_nxt   = ~r_port;
                    w_done1_nxt   = r_port;
                    w_err0_nxt    = w_timeout & ~r_port;
                    w_err1_nxt    = w_timeout & r_port;
                    w_psel1_nxt   = 1'b0;
                    w_psel2_nxt   = 1'b0;
                    w_penable_nxt = 1'b0;
                    if (w_timeout) begin
                        if (r_port) w_rdata1_nxt = '0;
                        else        w_rdata0_nxt = '0;
                    end else if (!PWRITE) begin
                        if (r_port) w_rdata1_nxt = w_prdata;
                        else        w_rdata0_nxt = w_prdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_apb_arbiter_master.sv
// Bench for apb_arbiter_master: two RAM slaves with random wait states, a
// transaction-level reference model checked every cycle, plus directed scenarios.
`timescale 1ns/1ps
module tb_apb_arbiter_master;
    localparam int SB = 10;
    localparam int TO = 16;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, write0 = 1'b0, write1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1, PADDR, PWDATA;
    logic        PWRITE, PSEL1, PSEL2, PENABLE;
    logic [31:0] PRDATA1 = '0, PRDATA2 = '0;
    logic        PREADY1 = 1'b0, PREADY2 = 1'b0;

    always #5 clk = ~clk;

    apb_arbiter_master #(.ADDR_SIZE(32), .DATA_WIDTH(32), .SEL_BIT(SB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .write0(write0), .write1(write1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
    );

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave RAMs ----------------
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];
    int lat1 = 0, lat2 = 0, cnt1 = 0, cnt2 = 0, force_lat = -1;
    bit stuck1 = 1'b0;

    // Mostly short waits, sometimes exactly at the timeout edge or one past it.
    function automatic int pick_lat();
        int r;
        if (force_lat >= 0) return force_lat;
        r = int'($urandom_range(0, 15));
        if (r < 11) return r % 4;
        if (r < 13) return TO - 1;
        return TO;
    endfunction

    always @(negedge clk) begin
        if (PSEL1 && PENABLE) begin
            if (!stuck1 && cnt1 == lat1) begin
                PREADY1 = 1'b1; PRDATA1 = mem1[PADDR[9:2]];
            end else begin
                PREADY1 = 1'b0; PRDATA1 = $urandom; cnt1++;
            end
        end else begin
            PREADY1 = 1'($urandom_range(0, 1)); PRDATA1 = $urandom; cnt1 = 0; lat1 = pick_lat();
        end
    end

    always @(negedge clk) begin
        if (PSEL2 && PENABLE) begin
            if (cnt2 == lat2) begin
                PREADY2 = 1'b1; PRDATA2 = mem2[PADDR[9:2]];
            end else begin
                PREADY2 = 1'b0; PRDATA2 = $urandom; cnt2++;
            end
        end else begin
            PREADY2 = 1'($urandom_range(0, 1)); PRDATA2 = $urandom; cnt2 = 0; lat2 = pick_lat();
        end
    end

    always @(posedge clk) begin
        if (rst_n && PENABLE && PWRITE) begin
            if (PSEL1 && PREADY1) mem1[PADDR[9:2]] = PWDATA;
            if (PSEL2 && PREADY2) mem2[PADDR[9:2]] = PWDATA;
        end
    end

    // ---------------- reference model ----------------
    bit          m_on = 1'b0, m_busy = 1'b0, m_acc = 1'b0, m_lg = 1'b1, m_wr = 1'b0;
    int          m_port = 0, m_wait = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [31:0] e_rd [2];
    bit          e_done [2];
    bit          e_err [2];
    logic [31:0] ref_mem [int];

    function automatic int mkey(input logic [31:0] a);
        return int'({a[SB], a[9:2]});
    endfunction

    always @(posedge clk) begin : model_p
        bit rdy;
        int k;
        m_on = 1'b1;
        e_done[0] = 1'b0; e_done[1] = 1'b0; e_err[0] = 1'b0; e_err[1] = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_acc = 1'b0; m_lg = 1'b1;
            m_addr = '0; m_wdata = '0; m_wr = 1'b0;
            e_rd[0] = '0; e_rd[1] = '0;
        end else if (!m_busy) begin
            if (req0 || req1) begin
                if (req0 && req1) m_port = m_lg ? 0 : 1;
                else              m_port = req1 ? 1 : 0;
                m_lg    = (m_port == 1);
                m_addr  = (m_port == 1) ? addr1 : addr0;
                m_wdata = (m_port == 1) ? wdata1 : wdata0;
                m_wr    = (m_port == 1) ? write1 : write0;
                m_busy  = 1'b1;
                m_acc   = 1'b0;
            end
        end else if (!m_acc) begin
            m_acc = 1'b1; m_wait = 0;
        end else begin
            rdy = m_addr[SB] ? PREADY2 : PREADY1;
            k = mkey(m_addr);
            if (rdy) begin
                if (m_wr) ref_mem[k] = m_wdata;
                else e_rd[m_port] = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
                e_done[m_port] = 1'b1; m_busy = 1'b0; m_acc = 1'b0;
            end else if (m_wait == TO - 1) begin
                e_rd[m_port] = '0; e_done[m_port] = 1'b1; e_err[m_port] = 1'b1;
                m_busy = 1'b0; m_acc = 1'b0;
            end else begin
                m_wait++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("PSEL1",   32'(PSEL1),   32'(m_busy && !m_addr[SB]));
            check("PSEL2",   32'(PSEL2),   32'(m_busy && m_addr[SB]));
            check("PENABLE", 32'(PENABLE), 32'(m_busy && m_acc));
            check("PADDR",   PADDR,        m_addr);
            check("PWDATA",  PWDATA,       m_wdata);
            check("PWRITE",  32'(PWRITE),  32'(m_wr));
            check("done0",   32'(done0),   32'(e_done[0]));
            check("done1",   32'(done1),   32'(e_done[1]));
            check("err0",    32'(err0),    32'(e_err[0]));
            check("err1",    32'(err1),    32'(e_err[1]));
            check("rdata0",  rdata0,       e_rd[0]);
            check("rdata1",  rdata1,       e_rd[1]);
        end
    end

    // ---------------- requester helpers ----------------
    int g_lat, g_tsel, g_ten;
    bit g_saw1, g_saw2;

    task automatic drive(input int p, input logic [31:0] a, input logic [31:0] d,
                         input bit w, input bit r);
        if (p == 0) begin addr0 = a; wdata0 = d; write0 = w; req0 = r; end
        else        begin addr1 = a; wdata1 = d; write1 = w; req1 = r; end
    endtask

    task automatic xfer(input int p, input logic [31:0] a, input logic [31:0] d, input bit w,
                        output logic [31:0] rd, output bit er);
        int n;
        bit got;
        @(negedge clk);
        drive(p, a, d, w, 1'b1);
        n = 0; got = 1'b0; g_tsel = 0; g_ten = 0; g_saw1 = 1'b0; g_saw2 = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk); n++;
            if ((PSEL1 || PSEL2) && g_tsel == 0) g_tsel = n;
            if (PENABLE && g_ten == 0) g_ten = n;
            g_saw1 = g_saw1 | PSEL1;
            g_saw2 = g_saw2 | PSEL2;
            got = (p == 1) ? done1 : done0;
        end
        check("xfer_done_seen", 32'(got), 32'd1);
        g_lat = n;
        rd = (p == 1) ? rdata1 : rdata0;
        er = (p == 1) ? err1 : err0;
        drive(p, a, d, w, 1'b0);
    endtask

    task automatic rand_req(input int p, input int cnt);
        int n;
        bit got;
        logic [31:0] a;
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = ($urandom & 32'hFFFF_F800) | (32'($urandom_range(0, 1)) << SB)
              | (32'($urandom_range(0, 7)) << 2);
            drive(p, a, $urandom, 1'($urandom_range(0, 1)), 1'b1);
            n = 0; got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk); n++;
                got = (p == 1) ? done1 : done0;
            end
            if (p == 1) check("rand1_done_seen", 32'(got), 32'd1);
            else        check("rand0_done_seen", 32'(got), 32'd1);
            drive(p, a, '0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main_p
        logic [31:0] rd;
        bit er, got, saw0, first2;
        int n, nd, cyc;
        int ord [4];
        int tm [4];
        for (int i = 0; i < 256; i++) begin mem1[i] = '0; mem2[i] = '0; end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_psel1", 32'(PSEL1), 32'd0);
        check("rst_psel2", 32'(PSEL2), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        rst_n = 1'b1;

        // write then read, slave answering on its second ACCESS cycle
        force_lat = 1;
        xfer(0, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1, rd, er);
        check("wr_latency", g_lat, 4);
        check("wr_psel_cycle", g_tsel, 1);
        check("wr_penable_cycle", g_ten, 2);
        check("wr_saw_psel1", 32'(g_saw1), 32'd1);
        check("wr_saw_psel2", 32'(g_saw2), 32'd0);
        check("wr_err0", 32'(er), 32'd0);
        check("wr_mem1", mem1[1], 32'hDEAD_BEEF);
        xfer(0, 32'h0000_0004, 32'h0, 1'b0, rd, er);
        check("rd_rdata0", rd, 32'hDEAD_BEEF);
        check("rd_err0", 32'(er), 32'd0);

        // slave decode through address bit 10
        xfer(1, 32'h0000_0404, 32'h1234_5678, 1'b1, rd, er);
        check("dec_saw_psel2", 32'(g_saw2), 32'd1);
        check("dec_saw_psel1", 32'(g_saw1), 32'd0);
        check("dec_mem2", mem2[1], 32'h1234_5678);
        check("dec_mem1_kept", mem1[1], 32'hDEAD_BEEF);
        xfer(1, 32'h0000_0404, 32'h0, 1'b0, rd, er);
        check("dec_rdata1", rd, 32'h1234_5678);

        // timeout on a slave that never answers
        stuck1 = 1'b1;
        xfer(0, 32'h0000_0008, 32'h0, 1'b0, rd, er);
        check("to_err0", 32'(er), 32'd1);
        check("to_rdata0", rd, 32'd0);
        check("to_latency", g_lat, 2 + TO);
        stuck1 = 1'b0;
        xfer(1, 32'h0000_0408, 32'h0000_A5A5, 1'b1, rd, er);
        check("to_next_err1", 32'(er), 32'd0);
        check("to_next_latency", g_lat, 4);

        // reset during ACCESS with req1 waiting
        stuck1 = 1'b1;
        @(negedge clk);
        drive(0, 32'h0000_000C, 32'h0, 1'b0, 1'b1);
        n = 0;
        while (!PENABLE && n < 20) begin @(negedge clk); n++; end
        check("mid_reached_access", 32'(PENABLE), 32'd1);
        drive(1, 32'h0000_040C, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_psel1", 32'(PSEL1), 32'd0);
        check("mid_penable", 32'(PENABLE), 32'd0);
        check("mid_paddr", PADDR, 32'd0);
        check("mid_done0", 32'(done0), 32'd0);
        check("mid_rdata1", rdata1, 32'd0);
        rst_n = 1'b1;
        stuck1 = 1'b0;
        n = 0; got = 1'b0; saw0 = 1'b0; first2 = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk); n++;
            if (n == 1) first2 = PSEL2 && !PSEL1;
            saw0 = saw0 | done0;
            got = done1;
        end
        check("mid_req1_served", 32'(got), 32'd1);
        check("mid_req1_first", 32'(first2), 32'd1);
        check("mid_no_done0", 32'(saw0), 32'd0);
        drive(1, 32'h0, 32'h0, 1'b0, 1'b0);

        // requester drops req during SETUP
        force_lat = 2;
        @(negedge clk);
        drive(0, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 1'b1);
        @(negedge clk);
        check("drop_setup_psel1", 32'(PSEL1), 32'd1);
        check("drop_setup_penable", 32'(PENABLE), 32'd0);
        drive(0, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 1'b0);
        n = 0; got = 1'b0;
        while (!got && n < 50) begin @(negedge clk); n++; got = done0; end
        check("drop_done0", 32'(got), 32'd1);
        check("drop_mem1", mem1[4], 32'hCAFE_F00D);

        // both requesting from reset: strict alternation, one IDLE cycle apart
        force_lat = 0;
        rst_n = 1'b0;
        @(negedge clk);
        drive(0, 32'h0000_0020, 32'h1111_0000, 1'b1, 1'b1);
        drive(1, 32'h0000_0420, 32'h2222_0000, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0; cyc = 0;
        while (nd < 4 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (done0 && nd < 4) begin
                ord[nd] = 0; tm[nd] = cyc; nd++;
                drive(0, 32'h0000_0020 + 32'(nd * 4), 32'h1111_0000 + 32'(nd), 1'b1, 1'b1);
            end
            if (done1 && nd < 4) begin
                ord[nd] = 1; tm[nd] = cyc; nd++;
                drive(1, 32'h0000_0420 + 32'(nd * 4), 32'h2222_0000 + 32'(nd), 1'b1, 1'b1);
            end
        end
        drive(0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1, 32'h0, 32'h0, 1'b0, 1'b0);
        check("rr_count", nd, 4);
        for (int k = 0; k < nd; k++) check("rr_order", ord[k], k % 2);
        for (int k = 0; k + 1 < nd; k++) check("rr_gap", tm[k + 1] - tm[k], 3);

        // randomized traffic on both ports
        force_lat = -1;
        @(negedge clk);
        fork
            rand_req(0, 60);
            rand_req(1, 60);
        join
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_arbiter_master.md
# apb_arbiter_master

Two-port APB master that shares the APB bus between two requesters (e.g. CPU and DMA) and drives up to two RAM slaves. Arbitration is round-robin. The block sequences each transfer through IDLE, SETUP and ACCESS, decodes the slave select from the address, waits on the selected slave's ready, and returns read data or an error to the winning requester. It sits between the requester logic and the slave RAMs at the top of the APB subsystem.

## Interface
- ADDR_SIZE, 32, address width
- DATA_WIDTH, 32, data width
- SEL_BIT, 10, address bit used for slave decode (0 selects slave 1, 1 selects slave 2)
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before the transfer is aborted

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req0, req1  in  1  transfer request, held high until the matching done pulse
- addr0, addr1  in  ADDR_SIZE  requester address
- wdata0, wdata1  in  DATA_WIDTH  requester write data
- write0, write1  in  1  1 = write, 0 = read
- done0, done1  out  1  one-cycle completion pulse
- err0, err1  out  1  timeout flag, valid with done
- rdata0, rdata1  out  DATA_WIDTH  read data, valid with done, held until next done on that port
- PADDR  out  ADDR_SIZE  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PWRITE  out  1  APB direction
- PSEL1, PSEL2  out  1  slave selects
- PENABLE  out  1  APB enable
- PRDATA1, PRDATA2  in  DATA_WIDTH  slave read data
- PREADY1, PREADY2  in  1  slave ready

## Operation
- **Reset values:** all outputs are 0, the FSM is in IDLE, last_grant = 1, and the timeout counter is 0.
- **IDLE:** sample req0 and req1.
  - If only one is high, grant it.
  - If both are high, grant the port that is not last_grant, then update last_grant.
  - On a grant, latch the granted port's addr, wdata and write into PADDR, PWDATA and PWRITE.
  - Assert PSEL1 when PADDR[SEL_BIT] = 0, otherwise PSEL2.
  - Go to SETUP.
- **SETUP:** hold PSELx = 1 and PENABLE = 0 for exactly one cycle, then go to ACCESS.
- **ACCESS:** PENABLE = 1 and PSELx is held. PADDR, PWDATA and PWRITE are stable for the whole transfer. Sample PREADY of the selected slave only.
  - **PREADY = 1:**
    - On a read, capture PRDATA of the selected slave into rdata of the granted port.
    - On a write, leave rdata unchanged.
    - Pulse done of the granted port with err = 0.
    - Clear PSELx and PENABLE, and return to IDLE.
  - **Timeout:** if the counter reaches TIMEOUT-1 while PREADY is still 0:
    - Pulse done with err = 1 and set that port's rdata to 0.
    - Clear PSELx and PENABLE, and return to IDLE.
- **Changes on req lines:** a requester dropping req mid-transfer does not abort the transfer; done still pulses. A new req arriving during SETUP or ACCESS is only evaluated in IDLE.
- **Unselected slave:** PREADY and PRDATA of the unselected slave are ignored.
- **Reset mid-transfer:** all outputs return to their reset values on the next edge. No done pulse is produced and no PSEL glitch occurs.

## Timing
- The FSM runs IDLE, SETUP, ACCESS, then back to IDLE. There is always at least one IDLE cycle between transfers.
- **Request latency:** with req sampled high in IDLE at edge N, PSELx rises at edge N, PENABLE rises at N+1, and done pulses at the edge after PREADY is sampled high.
- **Total cycles per transfer:** 2 + W, where W = ACCESS cycles including the PREADY cycle.
  - Example: a slave that asserts PREADY on its second ACCESS cycle gives W = 2.
- **Timeout:** the counter resets when entering ACCESS and increments each ACCESS cycle without PREADY. Abort occurs after exactly TIMEOUT ACCESS cycles.
- **Output stability:** done and err are registered, last one cycle, and are never asserted for both ports in the same cycle.

## Test plan
- **Write then read:** reset, then req0 writes 0xDEADBEEF to address 0x004. Expect PSEL1 high, PENABLE high one cycle later, and done0 after PREADY1. Then req0 reads 0x004 and gets rdata0 = 0xDEADBEEF, err0 = 0.
- **Slave decode:** req1 writes 0x12345678 to address 0x404. Expect PSEL2 = 1 with PSEL1 = 0 throughout. A read back returns 0x12345678 on rdata1.
- **Simultaneous requests:** req0 and req1 are both high from reset. Grant order is 0, 1, 0, 1 across four transfers, done pulses alternate, and there is one IDLE cycle between transfers.
- **Timeout:** PREADY1 is tied low and req0 reads 0x008. After 16 ACCESS cycles, done0 = 1, err0 = 1, rdata0 = 0, and the FSM returns to IDLE. A following req1 transfer completes normally.
- **Reset mid-transfer:** assert rst_n = 0 during ACCESS. Next cycle all outputs are 0 and no done pulse appears. After release, a pending req1 is served first (last_grant = 1).
- **Dropped request:** req0 drops during SETUP. The transfer still completes with done0 = 1 and the memory is written.
